mem_access_unit: RTL and testbench

MEM-stage data-memory access unit: the consumer of the EX/MEM pipeline register's memory controls. Turns MemRead/MemWrite, the ALU-computed address and store data into a ready-handshaked word-wide data-memory request. Stalls the pipeline while the access is outstanding and returns the loaded word to the MEM/WB side.

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-wide data-memory request/response bus
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access unit; optional trap via MEM_MISALIGN_TRAP_EN
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_in,
   input  logic [1:0]  MemWrite_in,
   input  logic [31:0] rd_data_in,
   input  logic [31:0] Read_data_2_in,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misaligned,
   mem_access_unit_if.master mem
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] load_data_q, load_data_d;
   logic        misaligned_q, misaligned_d;

   logic        access, is_store, misalign;
   logic [1:0]  lane;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt;

   assign lane     = rd_data_in[1:0];
   assign is_store = MemWrite_in != 2'b00;
   assign access   = MemRead_in | is_store;

   // Store wins over a simultaneous load; loads always fetch the whole word.
   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = 32'h0;
      case (MemWrite_in)
         2'b01: begin
            be_fmt    = 4'b0001 << lane;
            wdata_fmt = {4{Read_data_2_in[7:0]}};
         end
         2'b10: begin
            be_fmt    = lane[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{Read_data_2_in[15:0]}};
         end
         2'b11: begin
            be_fmt    = 4'b1111;
            wdata_fmt = Read_data_2_in;
         end
         default: begin
            be_fmt    = 4'b1111;
            wdata_fmt = 32'h0;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      if (is_store)
         misalign = (MemWrite_in == 2'b10 && lane[0]) ||
                    (MemWrite_in == 2'b11 && lane != 2'b00);
      else if (MemRead_in)
         misalign = lane != 2'b00;
   end
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= 4'b0000;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         load_data_q  <= 32'h0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         load_data_q  <= load_data_d;
         misaligned_q <= misaligned_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (access) state_d = misalign ? S_DONE : S_BUSY;
         S_BUSY:  if (mem.mem_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      load_data_d  = load_data_q;
      misaligned_d = 1'b0;
      stall        = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall = access;
            if (access && misalign) begin
               misaligned_d = 1'b1;
            end else if (access) begin
               mem_req_d   = 1'b1;
               mem_we_d    = is_store;
               mem_be_d    = be_fmt;
               mem_addr_d  = {rd_data_in[31:2], 2'b00};
               mem_wdata_d = wdata_fmt;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            if (mem.mem_ready) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) load_data_d = mem.mem_rdata;
            end
         end
         default: stall = 1'b0;
      endcase
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign load_data     = load_data_q;
   assign misaligned    = misaligned_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead_in;
   logic [1:0]  MemWrite_in;
   logic [31:0] rd_data_in;
   logic [31:0] Read_data_2_in;
   logic        stall;
   logic [31:0] load_data;
   logic        misaligned;

   mem_access_unit_if mem_bus ();

   mem_access_unit dut (
      .clk            (clk),
      .rst            (rst),
      .MemRead_in     (MemRead_in),
      .MemWrite_in    (MemWrite_in),
      .rd_data_in     (rd_data_in),
      .Read_data_2_in (Read_data_2_in),
      .stall          (stall),
      .load_data      (load_data),
      .misaligned     (misaligned),
      .mem            (mem_bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_load = 32'h0;

   typedef struct packed {
      logic        stall0;
      int          busy;
      int          stall_cnt;
      int          unstable;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        done_stall;
      logic        done_req;
      logic [31:0] done_load;
      logic        done_mis;
      logic        mis_stray;
      logic        timeout;
   } obs_t;

   typedef struct packed {
      logic        mis;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   // Reference: byte lanes from plain arithmetic on the byte offset.
   function automatic exp_t model(input logic rd, input logic [1:0] wr,
                                  input logic [31:0] addr, input logic [31:0] rs2);
      exp_t e;
      int   a;
      a = int'(addr % 32'd4);
      e = '0;
      e.addr = addr - 32'(a);
      if (wr != 2'b00) begin
         e.we = 1'b1;
         if (wr == 2'b01) begin
            e.be    = 4'(1 << a);
            e.wdata = 32'(rs2[7:0]) * 32'h0101_0101;
         end else if (wr == 2'b10) begin
            e.be    = 4'(3 << ((a / 2) * 2));
            e.wdata = 32'(rs2[15:0]) * 32'h0001_0001;
            e.mis   = (a % 2) != 0;
         end else begin
            e.be    = 4'hF;
            e.wdata = rs2;
            e.mis   = a != 0;
         end
      end else begin
         e.be  = 4'hF;
         e.mis = rd && (a != 0);
      end
`ifndef MEM_MISALIGN_TRAP_EN
      e.mis = 1'b0;
`endif
      return e;
   endfunction

   // Presents one instruction, plays the memory side and records what the unit did.
   task automatic run_access(input logic rd, input logic [1:0] wr, input logic [31:0] addr,
                             input logic [31:0] rs2, input int waitc, input logic [31:0] rdata,
                             output obs_t o);
      o = '0;
      MemRead_in = rd;
      MemWrite_in = wr;
      rd_data_in = addr;
      Read_data_2_in = rs2;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = $urandom;
      @(negedge clk);
      o.stall0 = stall;
      if (stall) o.stall_cnt++;
      if (misaligned) o.mis_stray = 1'b1;
      @(posedge clk); #1;
      while (mem_bus.mem_req && !o.timeout) begin
         mem_bus.mem_ready = (o.busy == waitc);
         mem_bus.mem_rdata = (o.busy == waitc) ? rdata : $urandom;
         @(negedge clk);
         if (o.busy == 0) begin
            o.we = mem_bus.mem_we;
            o.be = mem_bus.mem_be;
            o.addr = mem_bus.mem_addr;
            o.wdata = mem_bus.mem_wdata;
         end else if (o.we !== mem_bus.mem_we || o.be !== mem_bus.mem_be ||
                      o.addr !== mem_bus.mem_addr || o.wdata !== mem_bus.mem_wdata ||
                      stall !== 1'b1) begin
            o.unstable++;
         end
         if (stall) o.stall_cnt++;
         if (misaligned) o.mis_stray = 1'b1;
         o.busy++;
         @(posedge clk); #1;
         if (o.busy > waitc + 4) o.timeout = 1'b1;
      end
      mem_bus.mem_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      o.done_stall = stall;
      o.done_req = mem_bus.mem_req;
      o.done_load = load_data;
      o.done_mis = misaligned;
      if (stall) o.stall_cnt++;
      @(posedge clk); #1;
      mem_bus.mem_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      MemRead_in = 1'b0;
      MemWrite_in = 2'b00;
      rd_data_in = 32'h0;
      Read_data_2_in = 32'h0;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_bus.mem_req); end
      checks++; if (mem_bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_bus.mem_we); end
      checks++; if (mem_bus.mem_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %h expected 0", mem_bus.mem_be); end
      checks++; if (mem_bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_bus.mem_addr); end
      checks++; if (mem_bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mem_bus.mem_wdata); end
      checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load: got %h expected 0", load_data); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
      @(posedge clk); #1;
   endtask

   task automatic test_word_load;
      obs_t o;
      run_access(1'b1, 2'b00, 32'h100, 32'h0, 1, 32'hDEADBEEF, o);
      exp_load = 32'hDEADBEEF;
      checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL wl_addr: got %h expected 100", o.addr); end
      checks++; if (o.be !== 4'hF || o.we !== 1'b0) begin errors++; $display("FAIL wl_be_we: got %h/%b expected f/0", o.be, o.we); end
      checks++; if (o.stall0 !== 1'b1 || o.stall_cnt != 3) begin errors++; $display("FAIL wl_stall: got %0d cycles expected 3", o.stall_cnt); end
      checks++; if (o.done_stall !== 1'b0 || o.done_req !== 1'b0) begin errors++; $display("FAIL wl_done: got stall %b req %b expected 0 0", o.done_stall, o.done_req); end
      checks++; if (o.done_load !== exp_load) begin errors++; $display("FAIL wl_load: got %h expected %h", o.done_load, exp_load); end
   endtask

   task automatic test_byte_store;
      obs_t o;
      run_access(1'b0, 2'b01, 32'h203, 32'h123456AB, int'($urandom_range(2, 0)), 32'h5555_0000, o);
      checks++; if (o.addr !== 32'h200) begin errors++; $display("FAIL bs_addr: got %h expected 200", o.addr); end
      checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL bs_be: got %b expected 1000", o.be); end
      checks++; if (o.wdata !== 32'hABABABAB) begin errors++; $display("FAIL bs_wdata: got %h expected abababab", o.wdata); end
      checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL bs_we: got %b expected 1", o.we); end
      checks++; if (o.done_load !== exp_load) begin errors++; $display("FAIL bs_load: got %h expected %h", o.done_load, exp_load); end
   endtask

   task automatic test_half_store_wait;
      obs_t o;
      run_access(1'b0, 2'b10, 32'h302, 32'h0000BEEF, 5, 32'h0, o);
      checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL hs_be: got %b expected 1100", o.be); end
      checks++; if (o.wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL hs_wdata: got %h expected beefbeef", o.wdata); end
      checks++; if (o.busy != 6 || o.unstable != 0) begin errors++; $display("FAIL hs_hold: got busy %0d unstable %0d expected 6 0", o.busy, o.unstable); end
      checks++; if (o.stall_cnt != 7) begin errors++; $display("FAIL hs_stall: got %0d expected 7", o.stall_cnt); end
   endtask

   task automatic test_rw_conflict;
      obs_t o;
      run_access(1'b1, 2'b11, 32'h440, 32'hCAFE0123, 0, 32'h0BAD_0BAD, o);
      checks++; if (o.we !== 1'b1 || o.wdata !== 32'hCAFE0123) begin errors++; $display("FAIL rw_write: got we %b wdata %h expected 1 cafe0123", o.we, o.wdata); end
      checks++; if (o.busy != 1) begin errors++; $display("FAIL rw_single: got %0d request cycles expected 1", o.busy); end
      checks++; if (o.done_load !== exp_load) begin errors++; $display("FAIL rw_load: got %h expected %h", o.done_load, exp_load); end
   endtask

   task automatic test_misaligned_load;
      obs_t o;
      run_access(1'b1, 2'b00, 32'h101, 32'h0, 0, 32'h1234_5678, o);
`ifdef MEM_MISALIGN_TRAP_EN
      checks++; if (o.busy != 0) begin errors++; $display("FAIL mis_noreq: got %0d request cycles expected 0", o.busy); end
      checks++; if (o.done_mis !== 1'b1 || o.mis_stray !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b stray %b expected 1 0", o.done_mis, o.mis_stray); end
      checks++; if (o.stall_cnt != 1) begin errors++; $display("FAIL mis_stall: got %0d expected 1", o.stall_cnt); end
`else
      exp_load = 32'h1234_5678;
      checks++; if (o.addr !== 32'h100 || o.busy != 1) begin errors++; $display("FAIL mis_req: got addr %h busy %0d expected 100 1", o.addr, o.busy); end
      checks++; if (o.done_mis !== 1'b0 || o.mis_stray !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b stray %b expected 0 0", o.done_mis, o.mis_stray); end
`endif
      checks++; if (o.done_load !== exp_load) begin errors++; $display("FAIL mis_load: got %h expected %h", o.done_load, exp_load); end
   endtask

   task automatic test_reset_mid_access;
      MemRead_in = 1'b1;
      MemWrite_in = 2'b00;
      rd_data_in = 32'h880;
      mem_bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got req %b expected 1", mem_bus.mem_req); end
      rst = 1'b1;
      MemRead_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_load = 32'h0;
      @(negedge clk);
      checks++; if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got req %b stall %b expected 0 0", mem_bus.mem_req, stall); end
      checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_mid_load: got %h expected 0", load_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      obs_t o;
      exp_t e;
      logic [1:0] wr;
      logic rd;
      logic [31:0] addr, rs2, rdata;
      int waitc;
      for (int i = 0; i < 150; i++) begin
         wr = 2'($urandom_range(3, 0));
         rd = (wr == 2'b00) ? 1'b1 : 1'($urandom_range(1, 0));
         addr = $urandom;
         rs2 = $urandom;
         rdata = $urandom;
         waitc = int'($urandom_range(3, 0));
         e = model(rd, wr, addr, rs2);
         run_access(rd, wr, addr, rs2, waitc, rdata, o);
         if (!e.mis && wr == 2'b00) exp_load = rdata;
         checks++; if (o.timeout || o.busy != (e.mis ? 0 : waitc + 1)) begin errors++; $display("FAIL b2b_busy[%0d]: got %0d expected %0d", i, o.busy, e.mis ? 0 : waitc + 1); end
         checks++; if (o.stall0 !== 1'b1 || o.stall_cnt != (e.mis ? 1 : waitc + 2)) begin errors++; $display("FAIL b2b_stall[%0d]: got %0d expected %0d", i, o.stall_cnt, e.mis ? 1 : waitc + 2); end
         checks++; if (o.unstable != 0) begin errors++; $display("FAIL b2b_hold[%0d]: got %0d unstable cycles expected 0", i, o.unstable); end
         if (!e.mis) begin
            checks++; if (o.we !== e.we || o.be !== e.be || o.addr !== e.addr) begin errors++; $display("FAIL b2b_req[%0d]: got %b %b %h expected %b %b %h", i, o.we, o.be, o.addr, e.we, e.be, e.addr); end
            if (e.we) begin
               checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", i, o.wdata, e.wdata); end
            end
         end
         checks++; if (o.done_stall !== 1'b0 || o.done_req !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d]: got stall %b req %b expected 0 0", i, o.done_stall, o.done_req); end
         checks++; if (o.done_load !== exp_load) begin errors++; $display("FAIL b2b_load[%0d]: got %h expected %h", i, o.done_load, exp_load); end
         checks++; if (o.done_mis !== e.mis || o.mis_stray !== 1'b0) begin errors++; $display("FAIL b2b_mis[%0d]: got %b stray %b expected %b 0", i, o.done_mis, o.mis_stray, e.mis); end
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_store();
      test_half_store_wait();
      test_rw_conflict();
      test_misaligned_load();
      test_reset_mid_access();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
